keypad_scan: RTL and testbench

- Input-side counterpart of the multiplexed seven-segment display driver.
- Scans a 4x4 matrix keypad by driving one row low at a time and sampling the four column lines, then debounces press and release.
- Emits a one-cycle key event carrying a 4-bit hex code.
- Shifts each accepted digit into a 32-bit register that can feed the display's 32-bit data input directly.

---
 rtl/keypad_scan.sv | 181 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one row driven low per scan tick, 2-FF column sync,
// press/release debounce, one-cycle key event and a 32-bit digit shift register.
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 99999,
  parameter int unsigned DEBOUNCE_SCANS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  col_n,
  input  logic        clear,
  output logic [3:0]  row_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [31:0] data
);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

  localparam logic [16:0] DIV_MAX = 17'(SCAN_DIV);
  localparam logic [7:0]  DEB_N   = 8'(DEBOUNCE_SCANS);
  localparam logic        DEB_ONE = (DEBOUNCE_SCANS == 1);

  logic [3:0]  col_m_q, col_s_q;
  logic [16:0] div_q;
  state_t      state_q;
  logic [1:0]  row_q, lat_c_q;
  logic [3:0]  row_n_q;
  logic [7:0]  deb_q;
  logic [3:0]  key_code_q;
  logic        key_valid_q, key_held_q;
  logic [31:0] data_q;

  logic        tick, pressed, same_col, deb_hit, accept;
  logic [1:0]  col_idx;
  logic [7:0]  deb_inc;
  logic [3:0]  new_code;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_m_q <= 4'hF;
      col_s_q <= 4'hF;
    end else begin
      col_m_q <= col_n;
      col_s_q <= col_m_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 17'd1;
    end
  end

  assign tick = (div_q == DIV_MAX);

  // Several closed columns in one row resolve to the lowest index.
  always_comb begin
    col_idx = 2'd3;
    if (!col_s_q[0])      col_idx = 2'd0;
    else if (!col_s_q[1]) col_idx = 2'd1;
    else if (!col_s_q[2]) col_idx = 2'd2;
  end

  assign pressed  = (col_s_q != 4'hF);
  assign same_col = (col_idx == lat_c_q);
  assign deb_inc  = deb_q + 8'd1;
  assign deb_hit  = (deb_inc == DEB_N);
  assign new_code = {row_q, col_idx};

  always_comb begin
    accept = 1'b0;
    if (tick && pressed) begin
      case (state_q)
        SCAN:      accept = DEB_ONE;
        DEB_PRESS: accept = same_col && deb_hit;
        default:   accept = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SCAN;
      row_q      <= 2'd0;
      row_n_q    <= 4'b1110;
      lat_c_q    <= 2'd0;
      deb_q      <= 8'd0;
      key_held_q <= 1'b0;
    end else if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (pressed) begin
            lat_c_q <= col_idx;
            deb_q   <= 8'd1;
            if (DEB_ONE) begin
              key_held_q <= 1'b1;
              state_q    <= HELD;
            end else begin
              state_q <= DEB_PRESS;
            end
          end else begin
            row_q   <= row_q + 2'd1;
            row_n_q <= {row_n_q[2:0], row_n_q[3]};
          end
        end
        DEB_PRESS: begin
          if (pressed && same_col) begin
            if (deb_hit) begin
              key_held_q <= 1'b1;
              state_q    <= HELD;
            end else begin
              deb_q <= deb_inc;
            end
          end else begin
            state_q <= SCAN;
            row_q   <= row_q + 2'd1;
            row_n_q <= {row_n_q[2:0], row_n_q[3]};
          end
        end
        HELD: begin
          // Extra keys closing while held are ignored; only full release counts.
          if (!pressed) begin
            deb_q <= 8'd1;
            if (DEB_ONE) begin
              key_held_q <= 1'b0;
              state_q    <= SCAN;
              row_q      <= row_q + 2'd1;
              row_n_q    <= {row_n_q[2:0], row_n_q[3]};
            end else begin
              state_q <= DEB_REL;
            end
          end
        end
        DEB_REL: begin
          if (!pressed) begin
            if (deb_hit) begin
              key_held_q <= 1'b0;
              state_q    <= SCAN;
              row_q      <= row_q + 2'd1;
              row_n_q    <= {row_n_q[2:0], row_n_q[3]};
            end else begin
              deb_q <= deb_inc;
            end
          end else begin
            state_q <= HELD;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  // Clear wins over a simultaneous accept for data, but the event itself still fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      data_q      <= 32'd0;
    end else begin
      key_valid_q <= accept;
      if (accept) key_code_q <= new_code;
      if (clear) begin
        data_q <= 32'd0;
      end else if (accept) begin
        data_q <= {data_q[27:0], new_code};
      end
    end
  end

  assign row_n     = row_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign data      = data_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=3 (tick every 4 clk) and DEBOUNCE_SCANS=2.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  col_n;
  logic        clear;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [31:0] data;

  logic        key_on;
  logic [1:0]  key_row;
  logic [3:0]  key_cols;

  int n_checks = 0;
  int n_errors = 0;
  int ncyc     = 0;
  int vld_cnt  = 0;
  int v0;

  keypad_scan #(.SCAN_DIV(3), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .col_n     (col_n),
    .clear     (clear),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .data      (data)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] row_pat(input logic [1:0] r);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << r);
  endfunction

  // Keypad model: the pressed key pulls its columns low only while its row is driven.
  always_comb begin
    col_n = 4'hF;
    if (key_on && (row_n == row_pat(key_row))) col_n = key_cols;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      ncyc++;
      if (key_valid === 1'b1) vld_cnt++;
    end
  endtask

  // Moves to the negedge just after a scan-tick edge.
  task automatic align();
    while (ncyc % 4 != 0) cyc(1);
  endtask

  task automatic wait_row(input string tag, input logic [3:0] pat);
    align();
    for (int i = 0; i < 20 && row_n !== pat; i++) cyc(4);
    check(tag, row_n, pat);
  endtask

  task automatic wait_valid(input string tag, input logic [3:0] exp);
    int k;
    k = 0;
    while (key_valid !== 1'b1 && k < 200) begin
      cyc(1);
      k++;
    end
    check({tag, "_vld"}, key_valid, 1);
    check({tag, "_code"}, key_code, exp);
    cyc(1);
    check({tag, "_pulse"}, key_valid, 0);
  endtask

  task automatic wait_release(input string tag);
    int k;
    k = 0;
    while (key_held !== 1'b0 && k < 200) begin
      cyc(1);
      k++;
    end
    check({tag, "_rel"}, key_held, 0);
  endtask

  task automatic press_release(input string tag, input logic [1:0] r, input logic [3:0] cols,
                               input logic [3:0] code, input bit bounce);
    key_row  = r;
    key_cols = cols;
    key_on   = 1'b1;
    wait_valid(tag, code);
    align();
    cyc(8);
    key_on = 1'b0;
    if (bounce) begin
      cyc(4);
      check({tag, "_bnc_held"}, key_held, 1);
      key_on = 1'b1;
      cyc(4);
      check({tag, "_bnc_back"}, key_held, 1);
      key_on = 1'b0;
    end
    wait_release(tag);
  endtask

  initial begin
    reset_n  = 1'b0;
    clear    = 1'b0;
    key_on   = 1'b0;
    key_row  = 2'd0;
    key_cols = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_row", row_n, 4'b1110);
    check("rst_code", key_code, 0);
    check("rst_vld", key_valid, 0);
    check("rst_held", key_held, 0);
    check("rst_data", data, 0);
    reset_n = 1'b1;
    ncyc    = 0;

    // Idle scan: row steps on tick edges 4, 8, 12, 16.
    cyc(3);
    check("t1_row0", row_n, 4'b1110);
    cyc(1);
    check("t1_row1", row_n, 4'b1101);
    cyc(4);
    check("t1_row2", row_n, 4'b1011);
    cyc(4);
    check("t1_row3", row_n, 4'b0111);
    cyc(4);
    check("t1_wrap", row_n, 4'b1110);
    check("t1_novld", vld_cnt, 0);

    // Row 2 / col 1 held for a long time.
    v0       = vld_cnt;
    key_row  = 2'd2;
    key_cols = 4'b1101;
    key_on   = 1'b1;
    wait_valid("t2", 4'h9);
    cyc(40);
    check("t2_once", vld_cnt, v0 + 1);
    check("t2_data", data, 32'h0000_0009);
    check("t2_held", key_held, 1);
    check("t2_row", row_n, 4'b1011);
    align();
    key_on = 1'b0;
    wait_release("t2");
    check("t2_adv", row_n, 4'b0111);

    // One-tick bounce on row 0.
    wait_row("t3_sync", 4'b1110);
    v0       = vld_cnt;
    key_row  = 2'd0;
    key_cols = 4'b1110;
    key_on   = 1'b1;
    cyc(4);
    check("t3_hold", row_n, 4'b1110);
    key_on = 1'b0;
    cyc(4);
    check("t3_adv", row_n, 4'b1101);
    check("t3_novld", vld_cnt, v0);

    // Digit sequence 1, 2, 3, A with a release bounce on 3.
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("t4_clr", data, 0);
    v0 = vld_cnt;
    press_release("t4_1", 2'd0, 4'b1101, 4'h1, 1'b0);
    press_release("t4_2", 2'd0, 4'b1011, 4'h2, 1'b0);
    press_release("t4_3", 2'd0, 4'b0111, 4'h3, 1'b1);
    press_release("t4_A", 2'd2, 4'b1011, 4'hA, 1'b0);
    check("t4_data", data, 32'h0000_123A);
    check("t4_cnt", vld_cnt, v0 + 4);

    // Two columns closed: lowest wins.
    press_release("t5_multi", 2'd1, 4'b1001, 4'h5, 1'b0);
    check("t5_data", data, 32'h0001_23A5);

    // Clear coincident with an accept edge: row3 driven at E, detect E+4, accept E+8.
    wait_row("t5_sync", 4'b1011);
    key_row  = 2'd3;
    key_cols = 4'b1110;
    key_on   = 1'b1;
    cyc(4);
    check("t5_row3", row_n, 4'b0111);
    cyc(7);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("t5_clr_vld", key_valid, 1);
    check("t5_clr_code", key_code, 4'hC);
    check("t5_clr_data", data, 0);
    align();
    key_on = 1'b0;
    wait_release("t5_c");

    // Reset while in DEB_PRESS on row 2 / col 3.
    wait_row("t6_sync", 4'b1101);
    key_row  = 2'd2;
    key_cols = 4'b0111;
    key_on   = 1'b1;
    cyc(4);
    check("t6_row2", row_n, 4'b1011);
    cyc(4);
    check("t6_deb_row", row_n, 4'b1011);
    cyc(1);
    v0      = vld_cnt;
    reset_n = 1'b0;
    #1;
    check("t6_rst_row", row_n, 4'b1110);
    check("t6_rst_code", key_code, 0);
    check("t6_rst_vld", key_valid, 0);
    check("t6_rst_held", key_held, 0);
    check("t6_rst_data", data, 0);
    cyc(2);
    reset_n = 1'b1;
    ncyc    = 0;
    // Fresh run: row2 at edge 8, detect at 12, accept at 16.
    cyc(15);
    check("t6_early", vld_cnt, v0);
    check("t6_early_vld", key_valid, 0);
    cyc(1);
    check("t6_vld", key_valid, 1);
    check("t6_code", key_code, 4'hB);
    check("t6_data", data, 32'h0000_000B);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
